// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and encodings for the instruction/data memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // With both ports requesting, the one that did not own the previous access wins.
    function automatic logic pick_port(input logic [1:0] strobe, input logic last_grant);
        if (strobe[PORT_I] && strobe[PORT_D]) begin
            return ~last_grant;
        end
        return strobe[PORT_D];
    endfunction

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - down-counter that times the fixed memory wait states
module arb_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign last = (count_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_strobe,
    input  logic [1:0]        req_rw,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [DATA_W-1:0] req_rdata,
    output logic [1:0]        grant,
    output logic              mem_strobe,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_CYCLES);

    arb_state_t state_q, state_d;

    logic              take;
    logic              ctr_load;
    logic              ctr_last;
    logic              sel_port;
    logic              gnt_port_q;
    logic              last_grant_q;
    logic [1:0]        grant_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    assign sel_port = pick_port(req_strobe, last_grant_q);

    arb_wait_counter #(
        .W(CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (WAIT_VAL),
        .last     (ctr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        ctr_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_strobe) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ctr_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (ctr_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are captured once at grant; later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_port_q   <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            rw_q         <= RW_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (take) begin
                gnt_port_q <= sel_port;
                grant_q    <= port_onehot(sel_port);
                rw_q       <= req_rw[sel_port];
                addr_q     <= sel_port ? req_addr1 : req_addr0;
                wdata_q    <= sel_port ? req_wdata1 : req_wdata0;
            end
            if (state_q == DONE) begin
                grant_q      <= 2'b00;
                last_grant_q <= gnt_port_q;
                if (rw_q == RW_READ) begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Read data is forwarded in DONE so it is valid alongside req_ready, then held.
    assign req_rdata  = (state_q == DONE && rw_q == RW_READ) ? mem_rdata : rdata_q;
    assign req_ready  = (state_q == DONE) ? grant_q : 2'b00;
    assign grant      = grant_q;
    assign mem_strobe = (state_q == ISSUE);
    assign mem_rw     = rw_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_strobe;
    logic [1:0]    req_rw;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic [1:0]    req_ready;
    logic [DW-1:0] req_rdata;
    logic [1:0]    grant;
    logic          mem_strobe;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_strobe (req_strobe),
        .req_rw     (req_rw),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .req_rdata  (req_rdata),
        .grant      (grant),
        .mem_strobe (mem_strobe),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {16'h0000, a ^ 16'h0010};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a sampled request owns the port for cycles t0+1 .. t0+WC+2.
    int            cyc = 0;
    bit            m_busy = 0;
    int            m_t0 = 0;
    logic          m_port = 1'b0;
    logic          m_last = 1'b1;
    logic          m_rw = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata_hold = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy       <= 0;
            m_last       <= 1'b1;
            m_rw         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_rdata_hold <= '0;
        end else if (!m_busy) begin
            if (req_strobe != 2'b00) begin
                logic p;
                p = (req_strobe == 2'b11) ? ~m_last : req_strobe[1];
                m_busy  <= 1;
                m_t0    <= cyc;
                m_port  <= p;
                m_rw    <= req_rw[p];
                m_addr  <= p ? req_addr1 : req_addr0;
                m_wdata <= p ? req_wdata1 : req_wdata0;
            end
        end else if (cyc == m_t0 + WC + 2) begin
            m_busy <= 0;
            m_last <= m_port;
            if (!m_rw) m_rdata_hold <= mem_fn(m_addr);
        end
        cyc <= cyc + 1;
    end

    bit         done_c;
    logic [1:0] oh;

    always @(negedge clk) begin
        done_c    = m_busy && (cyc == m_t0 + WC + 2);
        mem_rdata = done_c ? mem_fn(m_addr) : 32'h0BAD_F00D;
        #1;
        if (run) begin
            oh = m_port ? 2'b10 : 2'b01;
            chk("grant", {30'd0, grant}, {30'd0, m_busy ? oh : 2'b00});
            chk("mem_strobe", {31'd0, mem_strobe}, {31'd0, m_busy && (cyc == m_t0 + 1)});
            chk("req_ready", {30'd0, req_ready}, {30'd0, done_c ? oh : 2'b00});
            chk("req_rdata", req_rdata, (done_c && !m_rw) ? mem_fn(m_addr) : m_rdata_hold);
            chk("mem_rw", {31'd0, mem_rw}, {31'd0, m_rw});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        int n;
        reset = 1'b1;
        req_strobe = 2'b00; req_rw = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        step();
        run = 1;
        step(2);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_mem_strobe", {31'd0, mem_strobe}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_req_rdata", req_rdata, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        reset = 1'b0;
        step();

        // single read, port 0
        req_strobe = 2'b01; req_rw = 2'b00; req_addr0 = 16'h0010;
        step();
        chk("rd_strobe", {31'd0, mem_strobe}, 32'd1);
        chk("rd_addr", {16'd0, mem_addr}, 32'h0010);
        chk("rd_rw", {31'd0, mem_rw}, 32'd0);
        step(5);
        chk("rd_ready", {30'd0, req_ready}, 32'd1);
        chk("rd_rdata", req_rdata, 32'hDEADBEEF);
        req_strobe = 2'b00;
        step(2);

        // single write, port 1
        req_strobe = 2'b10; req_rw = 2'b10; req_addr1 = 16'h00A4; req_wdata1 = 32'h12345678;
        step();
        chk("wr_strobe", {31'd0, mem_strobe}, 32'd1);
        chk("wr_rw", {31'd0, mem_rw}, 32'd1);
        chk("wr_addr", {16'd0, mem_addr}, 32'h00A4);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        step(5);
        chk("wr_ready", {30'd0, req_ready}, 32'd2);
        chk("wr_rdata_hold", req_rdata, 32'hDEADBEEF);
        req_strobe = 2'b00;
        step();
        chk("wr_rdata_after", req_rdata, 32'hDEADBEEF);
        step();

        // contention straight after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_strobe = 2'b11; req_rw = 2'b00; req_addr0 = 16'h0010; req_addr1 = 16'h0200;
        step();
        chk("ct_grant0", {30'd0, grant}, 32'd1);
        step(5);
        chk("ct_ready0", {30'd0, req_ready}, 32'd1);
        req_strobe = 2'b10;
        step(2);
        chk("ct_grant1", {30'd0, grant}, 32'd2);
        step(5);
        chk("ct_ready1", {30'd0, req_ready}, 32'd2);
        chk("ct_rdata1", req_rdata, 32'hDEADBEEF ^ 32'h0210);
        req_strobe = 2'b00;
        step(2);

        // round robin with both ports continuously requesting
        req_strobe = 2'b11; req_rw = 2'b10;
        req_addr0 = 16'h0100; req_addr1 = 16'h0300; req_wdata1 = 32'hAAAA5555;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            step();
            while (!mem_strobe && n < 12) begin
                step();
                n++;
            end
            chk("rr_timeout", {31'd0, n < 12}, 32'd1);
            chk("rr_grant", {30'd0, grant}, {30'd0, rr_exp[k]});
        end
        n = 0;
        while (req_ready == 2'b00 && n < 12) begin
            step();
            n++;
        end
        chk("rr_last_ready", {30'd0, req_ready}, 32'd2);
        req_strobe = 2'b00;
        step(2);

        // request fields changing mid-transaction
        req_strobe = 2'b01; req_rw = 2'b00; req_addr0 = 16'h0040;
        step(3);
        req_addr0 = 16'hFFFF; req_rw = 2'b01; req_wdata0 = 32'hCAFEF00D;
        step();
        chk("mc_addr_t4", {16'd0, mem_addr}, 32'h0040);
        step();
        chk("mc_addr_t5", {16'd0, mem_addr}, 32'h0040);
        step();
        chk("mc_addr_t6", {16'd0, mem_addr}, 32'h0040);
        chk("mc_rw_t6", {31'd0, mem_rw}, 32'd0);
        chk("mc_ready", {30'd0, req_ready}, 32'd1);
        chk("mc_rdata", req_rdata, 32'hDEADBEBF);
        req_strobe = 2'b00; req_rw = 2'b00;
        step(2);

        // reset in the middle of WAIT for a port 1 read
        req_strobe = 2'b10; req_addr1 = 16'h0500;
        step(3);
        reset = 1'b1; req_strobe = 2'b00;
        step();
        reset = 1'b0;
        chk("ab_grant", {30'd0, grant}, 32'd0);
        chk("ab_mem_strobe", {31'd0, mem_strobe}, 32'd0);
        chk("ab_ready", {30'd0, req_ready}, 32'd0);
        chk("ab_mem_addr", {16'd0, mem_addr}, 32'd0);
        req_strobe = 2'b11; req_addr0 = 16'h0010;
        step();
        chk("ab_first_grant", {30'd0, grant}, 32'd1);
        step(5);
        chk("ab_ready0", {30'd0, req_ready}, 32'd1);
        req_strobe = 2'b10;
        step(7);
        chk("ab_ready1", {30'd0, req_ready}, 32'd2);
        chk("ab_rdata1", req_rdata, 32'hDEADBEEF ^ 32'h0510);
        req_strobe = 2'b00;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache controller (port 0) and the data-cache controller (port 1).
- Each cache controller issues a strobe/rw request on a miss or write-through.
- The arbiter grants one requester at a time with round-robin priority.
- It drives the memory strobe, times the fixed memory wait states with an internal counter, then returns read data and a one-cycle ready to the granted requester.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data word width.
- WAIT_CYCLES, 4, memory wait states per access; legal range 1..255.

Ports:
- clk  in  1  clock. Single clock domain; all state updates on the rising edge of clk.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_strobe  in  2  per-port request; bit i = port i.
- req_rw  in  2  per-port direction; 1 = write, 0 = read.
- req_addr0, req_addr1  in  ADDR_W each  request addresses.
- req_wdata0, req_wdata1  in  DATA_W each  write data.
- req_ready  out  2  one-cycle completion pulse per port.
- req_rdata  out  DATA_W  read data, valid with req_ready, shared by both ports.
- grant  out  2  one-hot owner of the current transaction; 0 when idle.
- mem_strobe  out  1  one-cycle memory access start.
- mem_rw  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the DONE cycle.

Behaviour:
- Reset values: all outputs 0, state = IDLE, last_grant = 1 (so port 0 wins the first contention), counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No strobe: stay in IDLE.
  - Exactly one strobe: grant that port.
  - Both strobes: grant the port not equal to last_grant.
  - On grant: latch rw/addr/wdata of the granted port into registers, set grant one-hot, go to ISSUE.
- ISSUE (1 cycle): mem_strobe = 1; counter loaded with WAIT_CYCLES; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 1, go to DONE, so WAIT lasts exactly WAIT_CYCLES cycles.
- DONE (1 cycle):
  - req_ready[granted] = 1.
  - On a read, req_rdata captures mem_rdata (registered); it holds until the next read DONE.
  - On a write, req_rdata is unchanged.
  - last_grant is updated to the granted port; grant clears on exit; go to IDLE.
- Memory outputs: mem_rw, mem_addr and mem_wdata are driven from the latched registers throughout ISSUE..DONE and hold their last values in IDLE. mem_strobe is 1 only in ISSUE.
- Latency: the cycle a strobe is sampled in IDLE is t0; mem_strobe at t0+1; req_ready at t0+WAIT_CYCLES+2.
- Requester contract:
  - Hold strobe and address/data stable until req_ready.
  - Deassert strobe in the cycle after req_ready; otherwise a new transaction is started.
  - Changes to req_* inputs after the grant have no effect on the current transaction.
- Simultaneous events:
  - A strobe on the non-granted port while busy is held off, not lost; it is considered in the next IDLE cycle.
  - Arbitration occurs only in IDLE, so there is one dead cycle between back-to-back transactions.
- Reset mid-operation: the transaction is aborted, no req_ready is issued, and all outputs return to reset values on the next edge.
- Counter width: $clog2(WAIT_CYCLES+1); no wrap, since it only counts down from WAIT_CYCLES to 1.

Decomposition:
- Package mem_arb_pkg contains:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE};
  - constants PORT_I = 0, PORT_D = 1;
  - the RW_WRITE / RW_READ encodings.
- One sub-module, arb_wait_counter: inputs load and load_val; outputs last (count == 1). It is parameterised by width.
- The arbiter FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Single read, WAIT_CYCLES = 4: port 0 strobe, read, addr 0x0010 at t0; memory returns 0xDEADBEEF.
  - Required: mem_strobe at t0+1 with mem_addr = 0x0010 and mem_rw = 0.
  - Required: req_ready = 2'b01 at t0+6 with req_rdata = 0xDEADBEEF.
- Single write: port 1, addr 0x00A4, wdata 0x12345678.
  - Required: mem_strobe with mem_rw = 1, mem_addr = 0x00A4, mem_wdata = 0x12345678.
  - Required: req_ready = 2'b10 at t0+6; req_rdata unchanged.
- Contention after reset: both strobes at t0.
  - Required: port 0 completes at t0+6.
  - Required: port 1 is granted at t0+7 and req_ready = 2'b10 at t0+13.
- Round-robin fairness: both ports keep re-requesting for 4 transactions.
  - Required: grant sequence 01, 10, 01, 10; no port is starved.
- Reset mid-WAIT: reset asserted at t0+3 for one cycle.
  - Required: no req_ready for the aborted access; grant = 0 and mem_strobe = 0 at t0+4; last_grant = 1.
  - Required: a new port 1 request completes normally afterwards.
- Mid-transaction input change: port 0 changes req_addr0 to 0xFFFF during WAIT.
  - Required: mem_addr stays at the latched value until DONE.
